posit_scale_unit: RTL and testbench

Parametrised, pipelined scale (exponent) datapath for the posit multiply/divide path. It merges each operand's regime `k` and exponent field `e` into a signed scale `k*2^ES + e`. It adds the scales (multiply) or subtracts them (divide), applies the mantissa-normalisation adjustment, and saturates to the posit scale range rather than overflowing. Results go back out as regime/exponent, with NaR and zero classification. It sits between the operand decoders and the fraction/normalise/encode stages, and uses valid/ready handshakes on both sides.

---
 rtl/posit_scale_unit_if.sv | 45 ++++
 rtl/posit_scale_unit.sv | 157 +++++++++++++++
 tb/tb_posit_scale_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/posit_scale_unit_if.sv
// Valid/ready bundle between the posit operand decoders, the scale unit and the fraction stages.
interface posit_scale_unit_if #(
  parameter int ES      = 3,
  parameter int K_BITS  = 6,
  parameter int SCALE_W = K_BITS + ES + 2
);
  logic               in_valid;
  logic               in_ready;
  logic               op;
  logic [K_BITS-1:0]  k_a;
  logic [K_BITS-1:0]  k_b;
  logic [ES-1:0]      exp_a;
  logic [ES-1:0]      exp_b;
  logic               sign_a;
  logic               sign_b;
  logic               zero_a;
  logic               zero_b;
  logic               nar_a;
  logic               nar_b;
  logic [1:0]         norm_adj;
  logic               out_valid;
  logic               out_ready;
  logic [SCALE_W-1:0] scale_out;
  logic [K_BITS-1:0]  k_out;
  logic [ES-1:0]      exp_out;
  logic               sign_out;
  logic               nar_out;
  logic               zero_out;
  logic               ovf_out;
  logic               unf_out;

  modport master (
    output in_valid, op, k_a, k_b, exp_a, exp_b, sign_a, sign_b,
           zero_a, zero_b, nar_a, nar_b, norm_adj, out_ready,
    input  in_ready, out_valid, scale_out, k_out, exp_out, sign_out,
           nar_out, zero_out, ovf_out, unf_out
  );

  modport slave (
    input  in_valid, op, k_a, k_b, exp_a, exp_b, sign_a, sign_b,
           zero_a, zero_b, nar_a, nar_b, norm_adj, out_ready,
    output in_ready, out_valid, scale_out, k_out, exp_out, sign_out,
           nar_out, zero_out, ovf_out, unf_out
  );
endinterface

// File: rtl/posit_scale_unit.sv
// Two-stage scale datapath for posit multiply/divide: merge regime/exponent, add or subtract,
// saturate to the representable scale range, and split back into regime/exponent.
module posit_scale_unit #(
  parameter int ES      = 3,
  parameter int K_BITS  = 6,
  parameter int K_MAX   = 29,
  parameter int K_MIN   = -30,
  parameter int SCALE_W = K_BITS + ES + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  posit_scale_unit_if.slave bus
);

  localparam logic signed [SCALE_W-1:0] SCALE_MAX = SCALE_W'(K_MAX * (2 ** ES) + (2 ** ES) - 1);
  localparam logic signed [SCALE_W-1:0] SCALE_MIN = SCALE_W'(K_MIN * (2 ** ES));

  function automatic logic signed [SCALE_W-1:0] merge_scale(input logic [K_BITS-1:0] k,
                                                            input logic [ES-1:0]     e);
    logic signed [SCALE_W-1:0] k_ext;
    logic signed [SCALE_W-1:0] e_ext;
    k_ext = {{(SCALE_W-K_BITS){k[K_BITS-1]}}, k};
    e_ext = {{(SCALE_W-ES){1'b0}}, e};
    return (k_ext <<< ES) + e_ext;
  endfunction

  logic                      v1_r;
  logic signed [SCALE_W-1:0] sum1_r;
  logic                      sign1_r;
  logic                      nar1_r;
  logic                      zero1_r;

  logic                      v2_r;
  logic [SCALE_W-1:0]        scale_out_r;
  logic [K_BITS-1:0]         k_out_r;
  logic [ES-1:0]             exp_out_r;
  logic                      sign_out_r;
  logic                      nar_out_r;
  logic                      zero_out_r;
  logic                      ovf_out_r;
  logic                      unf_out_r;

  logic                      adv1_s;
  logic                      adv2_s;
  logic signed [SCALE_W-1:0] s_a_s;
  logic signed [SCALE_W-1:0] s_b_s;
  logic signed [SCALE_W-1:0] adj_s;
  logic signed [SCALE_W-1:0] sum_s;
  logic                      nar_in_s;
  logic                      zero_in_s;
  logic signed [SCALE_W-1:0] sat_s;
  logic                      ovf_s;
  logic                      unf_s;
  logic                      special_s;

  assign adv2_s = !v2_r || bus.out_ready;
  assign adv1_s = !v1_r || adv2_s;

  // Stage-1 arithmetic: operand scales and their sum or difference with the normalisation nudge.
  always_comb begin
    s_a_s = merge_scale(bus.k_a, bus.exp_a);
    s_b_s = merge_scale(bus.k_b, bus.exp_b);
    adj_s = {{(SCALE_W-2){bus.norm_adj[1]}}, bus.norm_adj};
    if (bus.op) begin
      sum_s = s_a_s - s_b_s + adj_s;
    end else begin
      sum_s = s_a_s + s_b_s + adj_s;
    end
    nar_in_s  = bus.nar_a | bus.nar_b | (bus.op & bus.zero_b);
    zero_in_s = !nar_in_s & (bus.zero_a | (!bus.op & bus.zero_b));
  end

  // Stage-2 saturation: clamp into the posit scale range instead of wrapping.
  always_comb begin
    sat_s     = sum1_r;
    ovf_s     = 1'b0;
    unf_s     = 1'b0;
    special_s = nar1_r | zero1_r;
    if (sum1_r > SCALE_MAX) begin
      sat_s = SCALE_MAX;
      ovf_s = 1'b1;
    end else if (sum1_r < SCALE_MIN) begin
      sat_s = SCALE_MIN;
      unf_s = 1'b1;
    end else begin
      sat_s = sum1_r;
    end
  end

  // Stage 1 register: captures operands only on accept, holds while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      sum1_r  <= '0;
      sign1_r <= 1'b0;
      nar1_r  <= 1'b0;
      zero1_r <= 1'b0;
    end else if (adv1_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum1_r  <= sum_s;
        sign1_r <= bus.sign_a ^ bus.sign_b;
        nar1_r  <= nar_in_s;
        zero1_r <= zero_in_s;
      end
    end
  end

  // Stage 2 register: output holding stage; special results force the numeric fields to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r        <= 1'b0;
      scale_out_r <= '0;
      k_out_r     <= '0;
      exp_out_r   <= '0;
      sign_out_r  <= 1'b0;
      nar_out_r   <= 1'b0;
      zero_out_r  <= 1'b0;
      ovf_out_r   <= 1'b0;
      unf_out_r   <= 1'b0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        nar_out_r  <= nar1_r;
        zero_out_r <= zero1_r;
        if (special_s) begin
          scale_out_r <= '0;
          k_out_r     <= '0;
          exp_out_r   <= '0;
          sign_out_r  <= 1'b0;
          ovf_out_r   <= 1'b0;
          unf_out_r   <= 1'b0;
        end else begin
          // Arithmetic shift floors negative scales, so -1 becomes k=-1 with a full exponent.
          scale_out_r <= sat_s;
          k_out_r     <= K_BITS'(sat_s >>> ES);
          exp_out_r   <= sat_s[ES-1:0];
          sign_out_r  <= sign1_r;
          ovf_out_r   <= ovf_s;
          unf_out_r   <= unf_s;
        end
      end
    end
  end

  assign bus.in_ready  = adv1_s;
  assign bus.out_valid = v2_r;
  assign bus.scale_out = scale_out_r;
  assign bus.k_out     = k_out_r;
  assign bus.exp_out   = exp_out_r;
  assign bus.sign_out  = sign_out_r;
  assign bus.nar_out   = nar_out_r;
  assign bus.zero_out  = zero_out_r;
  assign bus.ovf_out   = ovf_out_r;
  assign bus.unf_out   = unf_out_r;

endmodule

// File: tb/tb_posit_scale_unit.sv
// Directed bench for posit_scale_unit: vector table, backpressure and reset-in-flight sequences.
module tb_posit_scale_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  posit_scale_unit_if #(.ES(3), .K_BITS(6)) bus ();

  posit_scale_unit #(.ES(3), .K_BITS(6), .K_MAX(29), .K_MIN(-30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [5:0]  ka;
    logic [2:0]  ea;
    logic [5:0]  kb;
    logic [2:0]  eb;
    logic        sa, sb, za, zb, na, nb;
    logic [1:0]  adj;
    logic [10:0] x_scale;
    logic [5:0]  x_k;
    logic [2:0]  x_e;
    logic        x_sign, x_nar, x_zero, x_ovf, x_unf;
  } vec_t;

  function automatic vec_t mk(int op, int ka, int ea, int kb, int eb, int sa, int sb,
                              int za, int zb, int na, int nb, int adj,
                              int xs, int xk, int xe, int xsg, int xn, int xz, int xo, int xu);
    vec_t v;
    v.op = 1'(op); v.ka = 6'(ka); v.ea = 3'(ea); v.kb = 6'(kb); v.eb = 3'(eb);
    v.sa = 1'(sa); v.sb = 1'(sb); v.za = 1'(za); v.zb = 1'(zb); v.na = 1'(na); v.nb = 1'(nb);
    v.adj = 2'(adj);
    v.x_scale = 11'(xs); v.x_k = 6'(xk); v.x_e = 3'(xe);
    v.x_sign = 1'(xsg); v.x_nar = 1'(xn); v.x_zero = 1'(xz); v.x_ovf = 1'(xo); v.x_unf = 1'(xu);
    return v;
  endfunction

  function automatic logic [31:0] pack_out();
    return 32'({bus.scale_out, bus.k_out, bus.exp_out, bus.sign_out,
                bus.nar_out, bus.zero_out, bus.ovf_out, bus.unf_out});
  endfunction

  function automatic logic [31:0] pack_exp(vec_t v);
    return 32'({v.x_scale, v.x_k, v.x_e, v.x_sign, v.x_nar, v.x_zero, v.x_ovf, v.x_unf});
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.op = v.op; bus.k_a = v.ka; bus.exp_a = v.ea; bus.k_b = v.kb; bus.exp_b = v.eb;
    bus.sign_a = v.sa; bus.sign_b = v.sb; bus.zero_a = v.za; bus.zero_b = v.zb;
    bus.nar_a = v.na; bus.nar_b = v.nb; bus.norm_adj = v.adj;
  endtask

  // One isolated operation: accept, confirm nothing appears early, then check the result.
  task automatic run_one(vec_t v, string nm);
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 check({nm, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({nm, "_data"}, pack_out(), pack_exp(v));
  endtask

  vec_t vecs[16];
  vec_t bp[4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx;
    int rx;
    logic acc;
    logic drn;

    n_cmp = 0;
    n_bad = 0;
    //         op ka  ea kb  eb sa sb za zb na nb adj  scale  k  e sg nar zr ov un
    vecs[0]  = mk(0,  1, 2, -2, 5, 0, 1, 0, 0, 0, 0,  0,   -1, -1, 7, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1,  1, 2, -2, 5, 1, 1, 0, 0, 0, 0,  1,   22,  2, 6, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 29, 7, 29, 7, 0, 0, 0, 0, 0, 0,  0,  239, 29, 7, 0, 0, 0, 1, 0);
    vecs[3]  = mk(0,-30, 0,-30, 0, 1, 0, 0, 0, 0, 0,  0, -240,-30, 0, 1, 0, 0, 0, 1);
    vecs[4]  = mk(1,  1, 2,  3, 1, 1, 0, 0, 1, 0, 0,  0,    0,  0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(0,  1, 2,  3, 1, 1, 0, 0, 1, 0, 0,  0,    0,  0, 0, 0, 0, 1, 0, 0);
    vecs[6]  = mk(0,  1, 2,  3, 1, 0, 1, 0, 1, 1, 0,  0,    0,  0, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, -1,   -1, -1, 7, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 29, 7,  0, 0, 0, 0, 0, 0, 0, 0,  0,  239, 29, 7, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 29, 7,  0, 1, 0, 0, 0, 0, 0, 0,  0,  239, 29, 7, 0, 0, 0, 1, 0);
    vecs[10] = mk(0,-30, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, -240,-30, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0,-30, 0,  0, 0, 0, 0, 0, 0, 0, 0, -1, -240,-30, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(1,  0, 0, 29, 7, 0, 1, 0, 0, 0, 0,  0, -239,-30, 1, 1, 0, 0, 0, 0);
    vecs[13] = mk(1,  3, 3,  2, 2, 1, 1, 1, 0, 0, 0,  0,    0,  0, 0, 0, 0, 1, 0, 0);
    vecs[14] = mk(1,  3, 3,  2, 2, 1, 1, 1, 0, 0, 1,  0,    0,  0, 0, 0, 1, 0, 0, 0);
    vecs[15] = mk(1, 29, 7,-30, 0, 1, 0, 0, 0, 0, 0,  1,  239, 29, 7, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      bp[i] = mk(0, i, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9 * i, i, i, 0, 0, 0, 0, 0);
    end

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_outputs", pack_out(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: out_ready low for five cycles while four operations are offered.
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (tx < 4) begin
        drive(bp[tx]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc < 2) check($sformatf("bp_in_ready_c%0d", cyc), 32'(bus.in_ready), 32'd1);
      if (cyc >= 2 && cyc < 5) begin
        check($sformatf("bp_full_c%0d", cyc), 32'(bus.in_ready), 32'd0);
        check($sformatf("bp_hold_valid_c%0d", cyc), 32'(bus.out_valid), 32'd1);
        check($sformatf("bp_hold_data_c%0d", cyc), pack_out(), pack_exp(bp[0]));
      end
      acc = bus.in_valid & bus.in_ready;
      drn = bus.out_valid & bus.out_ready;
      if (drn) begin
        check($sformatf("bp_data%0d", rx), pack_out(), pack_exp(bp[rx]));
        check($sformatf("bp_cycle%0d", rx), 32'(cyc), 32'(5 + rx));
        rx++;
      end
      @(posedge clk);
      if (acc) tx++;
    end
    check("bp_count", 32'(rx), 32'd4);

    // Reset with two operations in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[2]);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("pre_rst_data", pack_out(), pack_exp(vecs[0]));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_outputs", pack_out(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(vecs[1], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
